// File: rtl/branch_rs_if.sv
// Dispatch / CDB / issue bundle for the branch reservation station.
// master: dispatch, CDB, flush and branch-unit side. slave: the station.
interface branch_rs_if #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
);
  localparam int CW = $clog2(DEPTH + 1);

  logic              alloc_valid;
  logic              alloc_ready;
  logic              alloc_jump;
  logic              alloc_branch;
  logic [2:0]        alloc_funct3;
  logic [31:0]       alloc_pc;
  logic [31:0]       alloc_imm;
  logic              alloc_taken;
  logic              alloc_rs1_rdy;
  logic [TAG_W-1:0]  alloc_rs1_tag;
  logic [31:0]       alloc_rs1_val;
  logic              alloc_rs2_rdy;
  logic [TAG_W-1:0]  alloc_rs2_tag;
  logic [31:0]       alloc_rs2_val;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [31:0]       cdb_value;
  logic              flush;

  logic              issue_valid;
  logic              issue_ready;
  logic              issue_jump;
  logic              issue_branch;
  logic [2:0]        issue_funct3;
  logic [31:0]       issue_pc;
  logic [31:0]       issue_imm;
  logic              issue_taken;
  logic [31:0]       issue_rs1_val;
  logic [31:0]       issue_rs2_val;
  logic [CW-1:0]     count;

  modport master (
    output alloc_valid, alloc_jump, alloc_branch, alloc_funct3, alloc_pc, alloc_imm,
           alloc_taken, alloc_rs1_rdy, alloc_rs1_tag, alloc_rs1_val,
           alloc_rs2_rdy, alloc_rs2_tag, alloc_rs2_val,
           cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
    input  alloc_ready, issue_valid, issue_jump, issue_branch, issue_funct3, issue_pc,
           issue_imm, issue_taken, issue_rs1_val, issue_rs2_val, count
  );

  modport slave (
    input  alloc_valid, alloc_jump, alloc_branch, alloc_funct3, alloc_pc, alloc_imm,
           alloc_taken, alloc_rs1_rdy, alloc_rs1_tag, alloc_rs1_val,
           alloc_rs2_rdy, alloc_rs2_tag, alloc_rs2_val,
           cdb_valid, cdb_tag, cdb_value, flush, issue_ready,
    output alloc_ready, issue_valid, issue_jump, issue_branch, issue_funct3, issue_pc,
           issue_imm, issue_taken, issue_rs1_val, issue_rs2_val, count
  );
endinterface

// File: rtl/branch_rs_scheduler.sv
// Branch reservation station: collapsing age-ordered queue (entry 0 oldest),
// CDB wakeup with alloc bypass, oldest-ready issue to the single branch unit,
// full discard on mispredict flush.
module branch_rs_scheduler #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 6
) (
  input logic       clk,
  input logic       reset,
  branch_rs_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [31:0]      val;
  } opnd_t;

  typedef struct packed {
    logic        jump;
    logic        branch;
    logic [2:0]  funct3;
    logic [31:0] pc;
    logic [31:0] imm;
    logic        taken;
    opnd_t       rs1;
    opnd_t       rs2;
  } ent_t;

  logic [DEPTH-1:0] valid_q, valid_d;
  ent_t             ent_q [DEPTH];
  ent_t             ent_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  // Shifted view with an always-empty slot on top so the collapse never indexes past the array.
  ent_t             wk [DEPTH+1];
  logic [DEPTH:0]   vx;
  ent_t             new_e;
  logic [CW-1:0]    wr;

  logic [IW-1:0]    sel;
  logic             any_rdy;
  logic             alloc_fire, issue_fire;

  // A not-ready operand captures a matching broadcast; ready operands are never touched.
  function automatic opnd_t wake(opnd_t o, logic cv, logic [TAG_W-1:0] ct, logic [31:0] cval);
    opnd_t r;
    r = o;
    if (!o.rdy && cv && (o.tag == ct)) begin
      r.rdy = 1'b1;
      r.val = cval;
    end
    return r;
  endfunction

  // Oldest (lowest index) entry with both operands ready; uses registered state only.
  always_comb begin
    sel     = '0;
    any_rdy = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && ent_q[i].rs1.rdy && ent_q[i].rs2.rdy) begin
        sel     = IW'(i);
        any_rdy = 1'b1;
      end
    end
  end

  assign bus.alloc_ready   = !reset && (count_q < CW'(DEPTH));
  assign bus.issue_valid   = !reset && !bus.flush && any_rdy;
  assign bus.issue_jump    = ent_q[sel].jump;
  assign bus.issue_branch  = ent_q[sel].branch;
  assign bus.issue_funct3  = ent_q[sel].funct3;
  assign bus.issue_pc      = ent_q[sel].pc;
  assign bus.issue_imm     = ent_q[sel].imm;
  assign bus.issue_taken   = ent_q[sel].taken;
  assign bus.issue_rs1_val = ent_q[sel].rs1.val;
  assign bus.issue_rs2_val = ent_q[sel].rs2.val;
  assign bus.count         = count_q;

  assign alloc_fire = bus.alloc_valid && bus.alloc_ready;
  assign issue_fire = bus.issue_valid && bus.issue_ready;

  // Next queue image: wake every entry, collapse over the issued slot, then append the new op.
  always_comb begin
    new_e.jump   = bus.alloc_jump;
    new_e.branch = bus.alloc_branch;
    new_e.funct3 = bus.alloc_funct3;
    new_e.pc     = bus.alloc_pc;
    new_e.imm    = bus.alloc_imm;
    new_e.taken  = bus.alloc_taken;
    new_e.rs1    = wake('{bus.alloc_rs1_rdy, bus.alloc_rs1_tag, bus.alloc_rs1_val},
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
    new_e.rs2    = wake('{bus.alloc_rs2_rdy, bus.alloc_rs2_tag, bus.alloc_rs2_val},
                        bus.cdb_valid, bus.cdb_tag, bus.cdb_value);

    wr = count_q - CW'(issue_fire);

    wk[DEPTH] = '0;
    vx[DEPTH] = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      wk[i]     = ent_q[i];
      wk[i].rs1 = wake(ent_q[i].rs1, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      wk[i].rs2 = wake(ent_q[i].rs2, bus.cdb_valid, bus.cdb_tag, bus.cdb_value);
      vx[i]     = valid_q[i];
    end

    for (int i = 0; i < DEPTH; i++) begin
      if (issue_fire && (IW'(i) >= sel)) begin
        ent_d[i]   = wk[i+1];
        valid_d[i] = vx[i+1];
      end else begin
        ent_d[i]   = wk[i];
        valid_d[i] = vx[i];
      end
      if (alloc_fire && (CW'(i) == wr)) begin
        ent_d[i]   = new_e;
        valid_d[i] = 1'b1;
      end
    end

    count_d = count_q + CW'(alloc_fire) - CW'(issue_fire);
  end

  // State update: reset beats flush, flush beats alloc/issue/wakeup.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ent_q   <= ent_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_branch_rs_scheduler.sv
// Randomized scoreboard bench for branch_rs_scheduler. The reference model is an
// age-ordered queue of ops; issued ops are pushed to exp_q and a negedge monitor
// pops and compares them when the DUT fires.
module tb_branch_rs_scheduler;
  localparam int DEPTH = 4;
  localparam int TAG_W = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_rs_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

  branch_rs_scheduler #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    bit              r1, r2;
    bit [TAG_W-1:0]  t1, t2;
    bit [31:0]       v1, v2;
    bit              j, b, tk;
    bit [2:0]        f3;
    bit [31:0]       pc, imm;
  } op_t;

  op_t mq[$];
  op_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_ready();
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].r1 && mq[i].r2) return i;
    return -1;
  endfunction

  // Model step at a clock edge, from the inputs held during the cycle that just ended.
  task automatic model_step();
    int n0, idx;
    op_t o;
    n0 = mq.size();
    if (reset || bus.flush) begin
      mq.delete();
      return;
    end
    idx = first_ready();
    if (idx >= 0 && bus.issue_ready) mq.delete(idx);
    for (int i = 0; i < mq.size(); i++) begin
      if (bus.cdb_valid && !mq[i].r1 && mq[i].t1 == bus.cdb_tag) begin mq[i].r1 = 1; mq[i].v1 = bus.cdb_value; end
      if (bus.cdb_valid && !mq[i].r2 && mq[i].t2 == bus.cdb_tag) begin mq[i].r2 = 1; mq[i].v2 = bus.cdb_value; end
    end
    if (bus.alloc_valid && n0 < DEPTH) begin
      o.j = bus.alloc_jump; o.b = bus.alloc_branch; o.f3 = bus.alloc_funct3; o.tk = bus.alloc_taken;
      o.pc = bus.alloc_pc; o.imm = bus.alloc_imm;
      o.r1 = bus.alloc_rs1_rdy; o.t1 = bus.alloc_rs1_tag; o.v1 = bus.alloc_rs1_val;
      o.r2 = bus.alloc_rs2_rdy; o.t2 = bus.alloc_rs2_tag; o.v2 = bus.alloc_rs2_val;
      if (!o.r1 && bus.cdb_valid && o.t1 == bus.cdb_tag) begin o.r1 = 1; o.v1 = bus.cdb_value; end
      if (!o.r2 && bus.cdb_valid && o.t2 == bus.cdb_tag) begin o.r2 = 1; o.v2 = bus.cdb_value; end
      mq.push_back(o);
    end
  endtask

  task automatic drive_idle();
    bus.alloc_valid = 0; bus.alloc_jump = 0; bus.alloc_branch = 0; bus.alloc_funct3 = 0;
    bus.alloc_pc = 0; bus.alloc_imm = 0; bus.alloc_taken = 0;
    bus.alloc_rs1_rdy = 0; bus.alloc_rs1_tag = 0; bus.alloc_rs1_val = 0;
    bus.alloc_rs2_rdy = 0; bus.alloc_rs2_tag = 0; bus.alloc_rs2_val = 0;
    bus.cdb_valid = 0; bus.cdb_tag = 0; bus.cdb_value = 0;
    bus.flush = 0; bus.issue_ready = 0;
  endtask

  task automatic drive_random(input int cyc);
    int rdy_pct;
    rdy_pct = ((cyc / 200) % 2 == 1) ? 80 : 15;
    bus.alloc_valid   = ($urandom_range(99) < 60);
    bus.alloc_jump    = $urandom_range(1);
    bus.alloc_branch  = !bus.alloc_jump;
    bus.alloc_funct3  = 3'($urandom_range(7));
    bus.alloc_pc      = $urandom;
    bus.alloc_imm     = $urandom;
    bus.alloc_taken   = $urandom_range(1);
    bus.alloc_rs1_rdy = ($urandom_range(99) < 40);
    bus.alloc_rs1_tag = TAG_W'($urandom_range(7));
    bus.alloc_rs1_val = $urandom;
    bus.alloc_rs2_rdy = ($urandom_range(99) < 40);
    bus.alloc_rs2_tag = TAG_W'($urandom_range(7));
    bus.alloc_rs2_val = $urandom;
    bus.cdb_valid     = ($urandom_range(99) < 50);
    bus.cdb_tag       = TAG_W'($urandom_range(7));
    bus.cdb_value     = $urandom;
    bus.flush         = ($urandom_range(99) < 2);
    bus.issue_ready   = ($urandom_range(99) < rdy_pct);
  endtask

  // Monitor: every DUT issue handshake must match the next expected op.
  always @(negedge clk) begin
    op_t e;
    if (!reset && bus.issue_valid && bus.issue_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("issue_pc",   bus.issue_pc, e.pc);
        chk("issue_imm",  bus.issue_imm, e.imm);
        chk("issue_rs1",  bus.issue_rs1_val, e.v1);
        chk("issue_rs2",  bus.issue_rs2_val, e.v2);
        chk("issue_ctrl", {26'd0, bus.issue_jump, bus.issue_branch, bus.issue_funct3, bus.issue_taken},
                          {26'd0, e.j, e.b, e.f3, e.tk});
      end
    end
  end

  initial begin
    int idx;
    bit exp_iv;
    drive_idle();
    reset = 1;
    repeat (2) begin
      @(posedge clk); #2;
      chk("rst_alloc_ready", bus.alloc_ready, 0);
      chk("rst_issue_valid", bus.issue_valid, 0);
      chk("rst_count", bus.count, 0);
    end
    mq.delete();
    reset = 0;
    #1;
    chk("post_rst_alloc_ready", bus.alloc_ready, 1);

    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = (cyc == 1500 || cyc == 1501);
      drive_random(cyc);
      #1;
      idx    = first_ready();
      exp_iv = !reset && !bus.flush && (idx >= 0);
      chk("count", bus.count, mq.size());
      chk("alloc_ready", bus.alloc_ready, (!reset && mq.size() < DEPTH));
      chk("issue_valid", bus.issue_valid, exp_iv);
      if (exp_iv && bus.issue_ready) exp_q.push_back(mq[idx]);
      @(posedge clk);
      model_step();
      #1;
    end
    drive_idle();
    reset = 0;
    @(negedge clk); #1;
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
